// File: rtl/intr_ctrl.sv
// intr_ctrl: multi-channel interrupt controller with set-dominant pending
// latches, sticky per-channel overflow flags and fixed-priority arbitration
// (lowest index wins). The presented channel ID is frozen until acknowledged.
// Optional build macro INTR_EDGE_EN: when defined, an event is a rising edge
// of set_i[i]; when undefined, every cycle with set_i[i]=1 is an event.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | intr_o low; presents the lowest enabled pending channel, if any
// ST_ACTIVE| intr_o high, intr_id_o frozen; waits for ack_i
module intr_ctrl #(
   parameter int NUM_CH = 4,
   parameter int ID_W   = 2
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [NUM_CH-1:0] set_i,
   input  logic [NUM_CH-1:0] en_i,
   input  logic              ack_i,
   output logic              intr_o,
   output logic [ID_W-1:0]   intr_id_o,
   output logic [NUM_CH-1:0] pend_o,
   output logic [NUM_CH-1:0] ovf_o
);

   typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

   state_t            state_q;
   logic              intr_q;
   logic [ID_W-1:0]   intr_id_q;
   logic [NUM_CH-1:0] pend_q, pend_d;
   logic [NUM_CH-1:0] ovf_q, ovf_d;
   logic [NUM_CH-1:0] evt;
   logic [NUM_CH-1:0] clr;
   logic [NUM_CH-1:0] cand;
   logic              cand_vld;
   logic [ID_W-1:0]   cand_idx;
   logic              ack_act;

`ifdef INTR_EDGE_EN
   logic [NUM_CH-1:0] set_prev_q;

   // Edge-detect history of the request lines.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         set_prev_q <= '0;
      end else begin
         set_prev_q <= set_i;
      end
   end

   assign evt = set_i & ~set_prev_q;
`else
   assign evt = set_i;
`endif

   assign ack_act = (state_q == ST_ACTIVE) && ack_i;

   // One-hot clear of the presented channel when it is acknowledged.
   always_comb begin
      clr = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         clr[i] = ack_act && (intr_id_q == ID_W'(i));
      end
   end

   // Set-dominant pending latch; overflow survives an ack only if a new event
   // arrives in the same cycle.
   always_comb begin
      pend_d = (pend_q & ~clr) | evt;
      ovf_d  = (ovf_q & ~clr) | (evt & pend_q & ~clr) | (ovf_q & evt & clr);
   end

   assign cand = pend_q & en_i;

   // Fixed priority: scan downwards so the lowest set index is kept last.
   always_comb begin
      cand_vld = 1'b0;
      cand_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (cand[i]) begin
            cand_vld = 1'b1;
            cand_idx = ID_W'(i);
         end
      end
   end

   // Pending and overflow state.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pend_q <= '0;
         ovf_q  <= '0;
      end else begin
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
      end
   end

   // Presentation FSM with registered intr/intr_id.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_IDLE;
         intr_q    <= 1'b0;
         intr_id_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cand_vld) begin
                  intr_id_q <= cand_idx;
                  intr_q    <= 1'b1;
                  state_q   <= ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               if (ack_i) begin
                  intr_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               intr_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign intr_o    = intr_q;
   assign intr_id_o = intr_id_q;
   assign pend_o    = pend_q;
   assign ovf_o     = ovf_q;

endmodule
